// File: rtl/noc_rr_merge_split.sv
// Round-robin merge of NUM_IN packet channels into a small output FIFO.
// Each FIFO entry keeps its source channel, and the address field is split off at the output.
module noc_rr_merge_split #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 11,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_IN-1:0]           in_valid,
    input  logic [NUM_IN*WIDTH-1:0]     in_data,
    output logic [NUM_IN-1:0]           in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-ADDR_W-1:0]     out_data,
    output logic [ADDR_W-1:0]           out_addr,
    output logic [$clog2(NUM_IN)-1:0]   out_src,
    output logic [$clog2(DEPTH):0]      fifo_count
);

    localparam int SW = $clog2(NUM_IN);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [SW-1:0] LAST_CH  = SW'(NUM_IN - 1);
    localparam logic [SW:0]   NUM_V    = (SW+1)'(NUM_IN);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SW-1:0]     ptr;
    logic [SW-1:0]     grant_idx;
    logic              grant_any;
    logic [SW:0]       cand;
    logic [NUM_IN-1:0] rot;
    logic [NUM_IN-1:0] grant_vec;
    logic              full;
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  pkt_in;
    logic [WIDTH-1:0]  head;

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  mem     [DEPTH];
    logic [SW-1:0]     src_mem [DEPTH];

    // Rotate the valid vector so bit 0 is the channel at ptr; the lowest set bit wins.
    always_comb begin
        rot       = NUM_IN'({in_valid, in_valid} >> ptr);
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!grant_any && rot[k]) begin
                grant_any = 1'b1;
                cand      = {1'b0, ptr} + (SW+1)'(k);
                grant_idx = (cand >= NUM_V) ? SW'(cand - NUM_V) : SW'(cand);
            end
        end
    end

    // A pop in the same cycle never makes room, so full blocks every channel outright.
    always_comb begin
        full      = (count == FULL_CNT);
        grant_vec = grant_any ? (NUM_IN'(1) << grant_idx) : '0;
        in_ready  = (full || reset) ? '0 : grant_vec;
        push      = |in_ready;
        pop       = out_valid && out_ready;
        pkt_in    = in_data[grant_idx*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                ptr    <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the occupancy count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]     <= pkt_in;
            src_mem[wr_ptr] <= grant_idx;
        end
    end

    always_comb begin
        head       = mem[rd_ptr];
        out_valid  = (count != '0);
        out_data   = head[WIDTH-1:ADDR_W];
        out_addr   = head[ADDR_W-1:0];
        out_src    = src_mem[rd_ptr];
        fifo_count = count;
    end

endmodule
